// File: rtl/cache_requester.sv
// Command sequencer in front of the 4-line write-back cache: one command at a time, hides the
// cache's stale-valid and repeated-request quirks. Define CACHE_REQ_TIMEOUT_EN for error timeouts.
module cache_requester #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_wren,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_valid,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StWait,
    StPreSettle,
    StPreWait,
    StResp
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   last_addr_q;
  logic                last_wren_q;

`ifdef CACHE_REQ_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign resp_err       = 1'b0;
`endif

  assign cmd_ready = (state_q == StIdle);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      last_addr_q <= '0;
      last_wren_q <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
`ifdef CACHE_REQ_TIMEOUT_EN
      resp_err    <= 1'b0;
      tmo_cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            mem_address <= cmd_addr;
            mem_data    <= cmd_data;
            last_addr_q <= cmd_addr;
`ifdef CACHE_REQ_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
            // The cache ignores a repeated request, so a repeated write is preceded by a read.
            if (cmd_wren && last_wren_q && (cmd_addr == last_addr_q)) begin
              mem_wren    <= 1'b0;
              last_wren_q <= 1'b0;
              state_q     <= StPreSettle;
            end else begin
              mem_wren    <= cmd_wren;
              last_wren_q <= cmd_wren;
              state_q     <= StSettle;
            end
          end
        end
        // mem_valid may still reflect the previous request here.
        StSettle:    state_q <= StWait;
        StPreSettle: state_q <= StPreWait;
        StWait: begin
          if (mem_valid) begin
            resp_data  <= mem_q;
            resp_valid <= 1'b1;
`ifdef CACHE_REQ_TIMEOUT_EN
            resp_err   <= 1'b0;
`endif
            state_q    <= StResp;
          end
`ifdef CACHE_REQ_TIMEOUT_EN
          else if (tmo_cnt_q == TimeoutLast) begin
            resp_data  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state_q    <= StResp;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        StPreWait: begin
          if (mem_valid) begin
            mem_wren    <= 1'b1;
            last_wren_q <= 1'b1;
            state_q     <= StSettle;
`ifdef CACHE_REQ_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
          end
`ifdef CACHE_REQ_TIMEOUT_EN
          else if (tmo_cnt_q == TimeoutLast) begin
            resp_data  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            state_q    <= StResp;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_requester.sv
// Bench for cache_requester: behavioural cache model as environment, golden memory array as
// reference, directed plan steps followed by randomized commands.
module tb_cache_requester;

  logic       clock = 1'b0;
  logic       resetn;
  logic       cmd_valid, cmd_ready, cmd_wren;
  logic [4:0] cmd_addr, mem_address;
  logic [7:0] cmd_data, mem_data, resp_data;
  logic       mem_wren, resp_valid, resp_ready, resp_err;
  logic       mem_valid = 1'b1;
  logic [7:0] mem_q     = 8'h00;

  always #5 clock = ~clock;

  cache_requester #(.ADDR_W(5), .DATA_W(8), .TIMEOUT(15)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_wren   (cmd_wren),
    .cmd_data   (cmd_data),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_q      (mem_q),
    .mem_valid  (mem_valid),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  // Cache model: direct-mapped 4 lines, acts only when {address,wren} changes, never reset.
  logic [7:0] ram [32];
  logic [2:0] tag [4];
  bit         dirty [4];
  logic [4:0] c_addr = '0;
  logic       c_wren = 1'b0;
  int         busy   = 0;
  bit         stall  = 0;

  task automatic cache_done(input logic [4:0] a, input logic w);
    if (w) ram[a] = mem_data;
    mem_q     <= ram[a];
    mem_valid <= 1'b1;
  endtask

  always @(posedge clock) begin
    if (mem_address != c_addr || mem_wren != c_wren) begin
      c_addr <= mem_address;
      c_wren <= mem_wren;
      if (stall) begin
        mem_valid <= 1'b0;
        busy      <= 0;
      end else if (tag[mem_address[1:0]] == mem_address[4:2]) begin
        dirty[mem_address[1:0]] = dirty[mem_address[1:0]] | mem_wren;
        cache_done(mem_address, mem_wren);
        busy <= 0;
      end else begin
        mem_valid <= 1'b0;
        busy      <= dirty[mem_address[1:0]] ? 5 : 3;
        tag[mem_address[1:0]]   = mem_address[4:2];
        dirty[mem_address[1:0]] = mem_wren;
      end
    end else if (busy == 1) begin
      cache_done(c_addr, c_wren);
      busy <= 0;
    end else if (busy > 1) begin
      busy <= busy - 1;
    end
  end

  // Reference: expected memory contents and last request the requester issued.
  logic [7:0] ref_mem [32];
  logic [4:0] last_addr = '0;
  logic       last_wren = 1'b0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag_s, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag_s, got, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [4:0] a, input logic [7:0] d, input int hold,
                     output int lat);
    logic       ident, wf, lat_ok;
    logic [7:0] exp_d, rd;
    int         wz;
    ident = w && (a == last_addr) && last_wren;
    exp_d = w ? d : ref_mem[a];
    check("cmd_ready idle", {31'b0, cmd_ready}, 32'd1);
    resp_ready = (hold == 0);
    cmd_valid  = 1'b1;
    cmd_wren   = w;
    cmd_addr   = a;
    cmd_data   = d;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_addr  = 5'($urandom);
    cmd_data  = 8'($urandom);
    cmd_wren  = 1'($urandom);
    check("cmd_ready busy", {31'b0, cmd_ready}, 32'd0);
    check("mem_address", {27'b0, mem_address}, {27'b0, a});
    wf  = mem_wren;
    wz  = 0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      if (!mem_wren) wz++;
      @(negedge clock);
      lat++;
    end
    check("resp_valid", {31'b0, resp_valid}, 32'd1);
    check("resp_data", {24'b0, resp_data}, {24'b0, exp_d});
    check("resp_err", {31'b0, resp_err}, 32'd0);
    check("mem_wren first", {31'b0, wf}, {31'b0, ident ? 1'b0 : w});
    check("mem_wren final", {31'b0, mem_wren}, {31'b0, w});
    check("mem_data held", {24'b0, mem_data}, {24'b0, d});
    lat_ok = (lat >= (ident ? 4 : 2));
    check("latency min", {31'b0, lat_ok}, 32'd1);
    if (ident) check("dummy read cycles", {31'b0, wz >= 2}, 32'd1);
    else       check("wren low cycles", wz, w ? 0 : lat);
    rd = resp_data;
    if (hold > 0) begin
      repeat (hold) @(negedge clock);
      check("bp resp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp resp_data", {24'b0, resp_data}, {24'b0, rd});
      check("bp cmd_ready", {31'b0, cmd_ready}, 32'd0);
      resp_ready = 1'b1;
    end
    @(negedge clock);
    check("resp consumed", {31'b0, resp_valid}, 32'd0);
    check("cmd_ready after resp", {31'b0, cmd_ready}, 32'd1);
    if (w) ref_mem[a] = d;
    last_addr = a;
    last_wren = w;
  endtask

  task automatic check_reset_outputs();
    check("rst mem_address", {27'b0, mem_address}, 32'd0);
    check("rst mem_data", {24'b0, mem_data}, 32'd0);
    check("rst mem_wren", {31'b0, mem_wren}, 32'd0);
    check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst resp_data", {24'b0, resp_data}, 32'd0);
    check("rst resp_err", {31'b0, resp_err}, 32'd0);
    check("rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic [4:0] sa;
    for (int i = 0; i < 32; i++) begin
      ram[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
    ram[5'h1A]     = 8'h3C;
    ref_mem[5'h1A] = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      tag[i]   = 3'd1;
      dirty[i] = 1'b0;
    end
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_wren   = 1'b0;
    cmd_addr   = '0;
    cmd_data   = '0;
    resp_ready = 1'b1;
    #12;
    check_reset_outputs();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    txn(1'b0, 5'h05, 8'h00, 0, lat);
    check("hit latency", lat, 2);
    txn(1'b0, 5'h1A, 8'h00, 0, lat);
    check("miss latency > 2", {31'b0, lat > 2}, 32'd1);
    txn(1'b1, 5'h12, 8'hAA, 0, lat);
    txn(1'b1, 5'h12, 8'h55, 0, lat);
    txn(1'b0, 5'h12, 8'h00, 0, lat);
    txn(1'b0, 5'h05, 8'h00, 5, lat);
    check("bp hit latency", lat, 2);

    for (int i = 0; i < 40; i++) begin
      logic       rw;
      logic [4:0] ra;
      rw = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? last_addr : 5'($urandom);
      txn(rw, ra, 8'($urandom), int'($urandom_range(0, 2)), lat);
    end

    // Cache never answers.
    stall      = 1;
    sa         = last_addr ^ 5'h01;
    cmd_valid  = 1'b1;
    cmd_wren   = 1'b0;
    cmd_addr   = sa;
    cmd_data   = 8'h77;
    @(negedge clock);
    cmd_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
`ifdef CACHE_REQ_TIMEOUT_EN
    check("timeout latency", lat, 16);
    check("timeout resp_valid", {31'b0, resp_valid}, 32'd1);
    check("timeout resp_err", {31'b0, resp_err}, 32'd1);
    check("timeout resp_data", {24'b0, resp_data}, 32'd0);
    @(negedge clock);
    check("timeout consumed", {31'b0, resp_valid}, 32'd0);
    stall     = 0;
    last_addr = sa;
    last_wren = 1'b0;
`else
    check("no response", {31'b0, resp_valid}, 32'd0);
    check("still busy", {31'b0, cmd_ready}, 32'd0);
    stall  = 0;
    resetn = 1'b0;
    @(negedge clock);
    resetn    = 1'b1;
    last_addr = '0;
    last_wren = 1'b0;
    repeat (6) @(negedge clock);
`endif

    // Reset while waiting on the cache.
    cmd_valid = 1'b1;
    cmd_wren  = 1'b0;
    cmd_addr  = 5'h1B;
    cmd_data  = 8'hA5;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    check("pre-reset mem_address", {27'b0, mem_address}, 32'h1B);
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clock);
    resetn    = 1'b1;
    last_addr = '0;
    last_wren = 1'b0;
    repeat (8) @(negedge clock);
    txn(1'b0, 5'h05, 8'h00, 0, lat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
